visualizador_led_param: RTL and testbench
=========================================

# visualizador_led_param

Parametrised, registered LED visualiser. It latches a WIDTH-bit value on a load strobe and drives 2**WIDTH LEDs in one of four display modes: one-hot, thermometer, blinking one-hot, or off. It also flashes all LEDs for a fixed number of cycles whenever the latched value changes. It sits between the accumulator/state registers and the board LED pins, and replaces the fixed 2-bit combinational decoder.

## Interface
Parameters:
- WIDTH, 2, bit width of the displayed value; LED count N = 2**WIDTH; legal range 1..5.
- BLINK_DIV, 25_000_000, clock cycles per blink half-period; must be ≥ 1.
- FLASH_CYCLES, 12_500_000, duration of the change flash in cycles; must be ≥ 1.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-high.
- valor  in  WIDTH  value to display; sampled only when cargar=1.
- cargar  in  1  load strobe; single-cycle or held.
- modo  in  2  display mode: 00 one-hot, 01 thermometer, 10 one-hot blinking, 11 off. Sampled every cycle; not latched.
- leds  out  N  LED drive; registered; bit i = LED i.
- destello  out  1  high while the change flash is active; registered.

## Operation
- Registers:
  - registro (WIDTH): the latched value.
  - estado: MOSTRAR or DESTELLO.
  - cnt_flash: counts 0..FLASH_CYCLES-1.
  - cnt_blink: counts 0..BLINK_DIV-1.
  - fase (1 bit): blink phase.
- Load: when cargar=1, registro ← valor at that edge.
- Change detect: cargar=1 and valor ≠ registro → estado ← DESTELLO and cnt_flash ← 0. This applies in either state, so the flash restarts.
- Equal load: cargar=1 with valor = registro leaves estado and cnt_flash untouched.
- DESTELLO:
  - cnt_flash increments each cycle.
  - When cnt_flash = FLASH_CYCLES-1 and no restarting load occurs, estado ← MOSTRAR.
- Blink counter:
  - cnt_blink free-runs in all states.
  - At BLINK_DIV-1 it wraps to 0 and fase toggles.
- Next leds value, from registro and fase as they stand before the edge:
  - DESTELLO and modo ≠ 11: all ones.
  - modo 11: all zeros, including during DESTELLO. destello still reflects the state.
  - modo 00: bit registro only.
  - modo 01: bits 0..registro set (registro+1 ones).
  - modo 10: one-hot when fase=1, zeros when fase=0.
- destello = (estado == DESTELLO), registered alongside leds.

## Timing
- Reset values:
  - registro = 0, estado = MOSTRAR, cnt_flash = 0, cnt_blink = 0, fase = 1.
  - leds = 0, destello = 0.
- Reset has priority over cargar in the same cycle.
- Load latency:
  - cargar sampled at edge k → registro updated at edge k.
  - leds shows the new value (or the flash) after edge k+1. Latency is 2 edges from the strobe.
- Flash length: destello is high for exactly FLASH_CYCLES consecutive cycles, starting the cycle after edge k+1.
- Blink: leds in modo 10 toggles every BLINK_DIV cycles; the first off phase starts BLINK_DIV+1 cycles after reset release.
- Mode change takes effect on the next edge (1-cycle latency). It does not reset cnt_blink or fase.
- Value 0 in thermometer mode lights LED 0 only. Value N-1 lights all LEDs.

## Structure
- Package visualizador_pkg holds:
  - modo_t enum (MODO_ONEHOT, MODO_TERMO, MODO_PARPADEO, MODO_APAGADO).
  - estado_t enum (MOSTRAR, DESTELLO).
- One sub-module, divisor_parpadeo. It is parametrised by BLINK_DIV, has inputs clk and rst, and outputs fase. It owns cnt_blink with width $clog2(BLINK_DIV+1).
- The top level holds registro, the FSM, cnt_flash and the output decode.

## Test plan
All scenarios use WIDTH=2, BLINK_DIV=4, FLASH_CYCLES=3.
1. Reset hold 3 cycles, modo=00 → leds=0000 and destello=0 during reset; leds=0001 one cycle after release.
2. modo=00, cargar pulse with valor=2 → destello=1 for 3 cycles with leds=1111, then leds=0100 and destello=0.
3. modo=01, load valor=3 → after the flash, leds=1111; then load 0 → after the flash, leds=0001.
4. Load valor=1, then a second load with valor=2 on the 2nd flash cycle → flash restarts, 4 total flash cycles, final leds=0100. Repeat-load of the same value during MOSTRAR → no flash.
5. modo=10 with registro=1 → leds toggles between 0010 and 0000 every 4 cycles. Switch to modo=11 mid-flash → leds=0000 next cycle while destello stays 1.
6. Assert rst during DESTELLO together with cargar=1 → next cycle registro=0, destello=0, leds=0000.

Source files
------------

// File: rtl/visualizador_pkg.sv
// rtl/visualizador_pkg.sv - shared display-mode and FSM-state types for the LED visualiser
package visualizador_pkg;

  typedef enum logic [1:0] {
    MODO_ONEHOT   = 2'b00,
    MODO_TERMO    = 2'b01,
    MODO_PARPADEO = 2'b10,
    MODO_APAGADO  = 2'b11
  } modo_t;

  typedef enum logic {
    MOSTRAR  = 1'b0,
    DESTELLO = 1'b1
  } estado_t;

endpackage

// File: rtl/divisor_parpadeo.sv
// rtl/divisor_parpadeo.sv - free-running blink divisor, toggles fase every BLINK_DIV cycles
module divisor_parpadeo #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic fase
);

  localparam int CW = $clog2(BLINK_DIV + 1);

  logic [CW-1:0] cnt_blink;

  // fase resets to 1 so a freshly loaded value is lit before the first off phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_blink <= '0;
      fase      <= 1'b1;
    end else if (cnt_blink == CW'(BLINK_DIV - 1)) begin
      cnt_blink <= '0;
      fase      <= ~fase;
    end else begin
      cnt_blink <= cnt_blink + 1'b1;
    end
  end

endmodule

// File: rtl/visualizador_led_param.sv
// rtl/visualizador_led_param.sv - registered LED visualiser with display modes and change flash
module visualizador_led_param
  import visualizador_pkg::*;
#(
  parameter int WIDTH        = 2,
  parameter int BLINK_DIV    = 25_000_000,
  parameter int FLASH_CYCLES = 12_500_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    valor,
  input  logic                cargar,
  input  logic [1:0]          modo,
  output logic [2**WIDTH-1:0] leds,
  output logic                destello
);

  localparam int N  = 2**WIDTH;
  localparam int FW = $clog2(FLASH_CYCLES + 1);

  logic [WIDTH-1:0] registro;
  estado_t          estado;
  logic [FW-1:0]    cnt_flash;
  logic             fase;
  logic [N-1:0]     one_hot;
  logic [N-1:0]     termo;
  logic [N-1:0]     leds_next;
  logic             cambio;

  divisor_parpadeo #(
    .BLINK_DIV(BLINK_DIV)
  ) u_divisor (
    .clk (clk),
    .rst (rst),
    .fase(fase)
  );

  assign cambio = cargar && (valor != registro);

  // Thermometer wraps to all ones when registro = N-1 since the shifted bit falls off.
  always_comb begin
    one_hot = N'(1) << registro;
    termo   = (one_hot << 1) - N'(1);
    leds_next = '0;
    if (modo_t'(modo) == MODO_APAGADO) begin
      leds_next = '0;
    end else if (estado == DESTELLO) begin
      leds_next = '1;
    end else begin
      case (modo_t'(modo))
        MODO_ONEHOT:   leds_next = one_hot;
        MODO_TERMO:    leds_next = termo;
        MODO_PARPADEO: leds_next = fase ? one_hot : '0;
        default:       leds_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      registro  <= '0;
      estado    <= MOSTRAR;
      cnt_flash <= '0;
      leds      <= '0;
      destello  <= 1'b0;
    end else begin
      if (cargar) registro <= valor;
      if (cambio) begin
        estado    <= DESTELLO;
        cnt_flash <= '0;
      end else if (estado == DESTELLO) begin
        if (cnt_flash == FW'(FLASH_CYCLES - 1)) begin
          estado    <= MOSTRAR;
          cnt_flash <= '0;
        end else begin
          cnt_flash <= cnt_flash + 1'b1;
        end
      end
      leds     <= leds_next;
      destello <= (estado == DESTELLO);
    end
  end

endmodule

// File: tb/tb_visualizador_led_param.sv
// tb/tb_visualizador_led_param.sv - self-checking bench for visualizador_led_param
module tb_visualizador_led_param;

  localparam int W  = 2;
  localparam int N  = 4;
  localparam int BD = 4;
  localparam int FC = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] valor = '0;
  logic         cargar = 1'b0;
  logic [1:0]   modo = 2'b00;
  logic [N-1:0] leds;
  logic         destello;

  int checks = 0;
  int errors = 0;

  // Reference model: value, edges since reset release, edge of last change.
  int m_reg = 0;
  int m_n = 0;
  int m_chg_n = 0;
  bit m_chg = 1'b0;
  logic [N-1:0] exp_leds = '0;
  logic         exp_dest = 1'b0;

  visualizador_led_param #(
    .WIDTH(W),
    .BLINK_DIV(BD),
    .FLASH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valor(valor),
    .cargar(cargar),
    .modo(modo),
    .leds(leds),
    .destello(destello)
  );

  always #5 clk = ~clk;

  task automatic tick();
    bit dest_pre, fase_pre;
    int oh, th, val;
    if (rst) begin
      exp_leds = '0;
      exp_dest = 1'b0;
      m_reg = 0;
      m_n = 0;
      m_chg = 1'b0;
    end else begin
      dest_pre = m_chg && ((m_n - m_chg_n) < FC);
      fase_pre = ((m_n / BD) % 2) == 0;
      oh = 1 << m_reg;
      th = (1 << (m_reg + 1)) - 1;
      exp_dest = dest_pre;
      if (modo == 2'b11) exp_leds = '0;
      else if (dest_pre) exp_leds = N'((1 << N) - 1);
      else if (modo == 2'b00) exp_leds = N'(oh);
      else if (modo == 2'b01) exp_leds = N'(th);
      else exp_leds = fase_pre ? N'(oh) : '0;
      m_n++;
      val = int'(valor);
      if (cargar) begin
        if (val != m_reg) begin
          m_chg = 1'b1;
          m_chg_n = m_n;
        end
        m_reg = val;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; modo = 2'b00; cargar = 1'b0; valor = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (leds !== 4'b0000 || destello !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: leds=%b destello=%b required 0000/0", i, leds, destello);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (leds !== 4'b0001 || destello !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: leds=%b destello=%b required 0001/0", leds, destello);
    end
  endtask

  task automatic test_onehot_flash();
    modo = 2'b00; valor = 2'd2; cargar = 1'b1;
    tick();
    cargar = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (leds !== exp_leds || destello !== exp_dest) begin
        errors++;
        $display("FAIL onehot_flash cycle %0d: leds=%b destello=%b required %b/%b", i, leds, destello, exp_leds, exp_dest);
      end
      checks++;
      if (i < 3 && (leds !== 4'b1111 || destello !== 1'b1)) begin
        errors++;
        $display("FAIL onehot_flash_on cycle %0d: leds=%b destello=%b required 1111/1", i, leds, destello);
      end else if (i >= 3 && (leds !== 4'b0100 || destello !== 1'b0)) begin
        errors++;
        $display("FAIL onehot_flash_after cycle %0d: leds=%b destello=%b required 0100/0", i, leds, destello);
      end
    end
  endtask

  task automatic test_thermo();
    logic [N-1:0] want [2];
    logic [W-1:0] vals [2];
    want[0] = 4'b1111; want[1] = 4'b0001;
    vals[0] = 2'd3;    vals[1] = 2'd0;
    modo = 2'b01;
    for (int k = 0; k < 2; k++) begin
      valor = vals[k]; cargar = 1'b1;
      tick();
      cargar = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        checks++;
        if (leds !== exp_leds || destello !== exp_dest) begin
          errors++;
          $display("FAIL thermo_model val %0d cycle %0d: leds=%b destello=%b required %b/%b", vals[k], i, leds, destello, exp_leds, exp_dest);
        end
      end
      checks++;
      if (leds !== want[k] || destello !== 1'b0) begin
        errors++;
        $display("FAIL thermo_final val %0d: leds=%b destello=%b required %b/0", vals[k], leds, destello, want[k]);
      end
    end
  endtask

  task automatic test_restart();
    int high = 0;
    modo = 2'b00;
    valor = 2'd1; cargar = 1'b1;
    tick();
    valor = 2'd2;
    for (int i = 0; i < 8; i++) begin
      tick();
      cargar = 1'b0;
      if (destello === 1'b1) high++;
      checks++;
      if (leds !== exp_leds || destello !== exp_dest) begin
        errors++;
        $display("FAIL restart_model cycle %0d: leds=%b destello=%b required %b/%b", i, leds, destello, exp_leds, exp_dest);
      end
    end
    checks++;
    if (high != 4) begin
      errors++;
      $display("FAIL restart_len: flash cycles=%0d required 4", high);
    end
    checks++;
    if (leds !== 4'b0100) begin
      errors++;
      $display("FAIL restart_final: leds=%b required 0100", leds);
    end
    valor = 2'd2; cargar = 1'b1;
    tick();
    cargar = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (destello !== 1'b0 || leds !== 4'b0100) begin
        errors++;
        $display("FAIL same_load cycle %0d: leds=%b destello=%b required 0100/0", i, leds, destello);
      end
    end
  endtask

  task automatic test_blink_off();
    bit saw_on = 1'b0, saw_off = 1'b0;
    modo = 2'b00; valor = 2'd1; cargar = 1'b1;
    tick();
    cargar = 1'b0;
    repeat (5) tick();
    modo = 2'b10;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (leds === 4'b0010) saw_on = 1'b1;
      if (leds === 4'b0000) saw_off = 1'b1;
      checks++;
      if (leds !== exp_leds || destello !== exp_dest) begin
        errors++;
        $display("FAIL blink_model cycle %0d: leds=%b destello=%b required %b/%b", i, leds, destello, exp_leds, exp_dest);
      end
    end
    checks++;
    if (!(saw_on && saw_off)) begin
      errors++;
      $display("FAIL blink_toggle: saw_on=%0d saw_off=%0d required 1/1", saw_on, saw_off);
    end
    valor = 2'd2; cargar = 1'b1;
    tick();
    cargar = 1'b0;
    tick();
    modo = 2'b11;
    tick();
    checks++;
    if (leds !== 4'b0000 || destello !== 1'b1) begin
      errors++;
      $display("FAIL off_mid_flash: leds=%b destello=%b required 0000/1", leds, destello);
    end
  endtask

  task automatic test_reset_during_flash();
    rst = 1'b1; cargar = 1'b1; valor = 2'd3; modo = 2'b00;
    tick();
    checks++;
    if (leds !== 4'b0000 || destello !== 1'b0) begin
      errors++;
      $display("FAIL reset_flash: leds=%b destello=%b required 0000/0", leds, destello);
    end
    rst = 1'b0; cargar = 1'b0;
    tick();
    checks++;
    if (leds !== 4'b0001 || destello !== 1'b0) begin
      errors++;
      $display("FAIL reset_flash_reg: leds=%b destello=%b required 0001/0", leds, destello);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 39) == 0);
      cargar = ($urandom_range(0, 3) == 0);
      valor  = W'($urandom_range(0, N - 1));
      if ($urandom_range(0, 7) == 0) modo = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (leds !== exp_leds || destello !== exp_dest) begin
        errors++;
        $display("FAIL random cycle %0d: leds=%b destello=%b required %b/%b", i, leds, destello, exp_leds, exp_dest);
      end
    end
  endtask

  initial begin
    test_reset();
    test_onehot_flash();
    test_thermo();
    test_restart();
    test_blink_off();
    test_reset_during_flash();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
